// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_rx_state_t;

    // FIFO entry carries {framing_err, parity_err, data}.
    function automatic int unsigned entry_width(input int unsigned data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra pointer bit for full/empty; head is zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; wrap is implicit in the AW+1 bit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronizer, framing FSM and receive FIFO with sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter parity_t     PARITY      = PAR_NONE,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_rx,
    input  logic                 io_data_ready,
    input  logic                 io_clear_overrun,
    output logic                 io_data_valid,
    output logic [DATA_BITS-1:0] io_data_packet,
    output logic                 io_parity_error,
    output logic                 io_framing_error,
    output logic                 io_overrun
);

    localparam int unsigned BIT_CYCLES  = CLK_FREQ_HZ / BAUD;
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned EW          = entry_width(DATA_BITS);

    logic                 rx_meta;
    logic                 rx_s;
    uart_rx_state_t       state,    state_nxt;
    logic [CNT_W-1:0]     cnt,      cnt_nxt;
    logic [IDX_W-1:0]     idx,      idx_nxt;
    logic [DATA_BITS-1:0] shreg,    shreg_nxt;
    logic                 par_err,  par_err_nxt;
    logic                 frm_err,  frm_err_nxt;
    logic                 frame_push;
    logic [EW-1:0]        entry;
    logic [EW-1:0]        head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Two-flop synchronizer; idles high like the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= io_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par_err <= par_err_nxt;
            frm_err <= frm_err_nxt;
        end
    end

    // Next-state logic; samples mid-bit and pushes at the last stop sample.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        shreg_nxt   = shreg;
        par_err_nxt = par_err;
        frm_err_nxt = frm_err;
        frame_push  = 1'b0;
        entry       = '0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt   = START;
                    cnt_nxt     = '0;
                    idx_nxt     = '0;
                    par_err_nxt = 1'b0;
                    frm_err_nxt = 1'b0;
                end
            end
            START: begin
                if (cnt == CNT_W'(HALF_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PAR: begin
                if (cnt == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_nxt     = '0;
                    par_err_nxt = ((^shreg) ^ rx_s) != (PARITY == PAR_ODD);
                    state_nxt   = STOP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_nxt     = '0;
                    frm_err_nxt = frm_err | ~rx_s;
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_nxt    = '0;
                        frame_push = 1'b1;
                        entry      = {frm_err_nxt, par_err, shreg};
                        state_nxt  = IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop = io_data_valid && io_data_ready;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (frame_push),
        .wdata (entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign io_data_valid    = !fifo_empty;
    assign io_data_packet   = head[DATA_BITS-1:0];
    assign io_parity_error  = head[DATA_BITS];
    assign io_framing_error = head[DATA_BITS+1];

    // Sticky overrun: a dropped frame sets it and wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_overrun <= 1'b0;
        end else if (frame_push && fifo_full && !pop) begin
            io_overrun <= 1'b1;
        end else if (io_clear_overrun) begin
            io_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo across four parameterisations with a scoreboard queue.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx    [4];
    logic       ready [4];
    logic       clr   [4];
    logic       valid [4];
    logic       pe    [4];
    logic       fe    [4];
    logic       ovr   [4];
    logic [7:0] pkt_def;
    logic [7:0] pkt_n81;
    logic [7:0] pkt_even;
    logic [6:0] pkt_odd7;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cyc   = 0;
    int rise_cyc    = -1;
    int v0_high     = 0;
    logic v0_prev   = 1'b0;
    logic [10:0] mon_entry = '0;
    logic [10:0] sb [$];
    logic [10:0] exp_e;

    localparam int FAST = 16;
    localparam int SLOW = 868;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo u_def (
        .clk(clk), .reset(reset), .io_rx(rx[0]), .io_data_ready(ready[0]),
        .io_clear_overrun(clr[0]), .io_data_valid(valid[0]), .io_data_packet(pkt_def),
        .io_parity_error(pe[0]), .io_framing_error(fe[0]), .io_overrun(ovr[0]));

    uart_rx_fifo #(.CLK_FREQ_HZ(1_600_000), .BAUD(100_000)) u_n81 (
        .clk(clk), .reset(reset), .io_rx(rx[1]), .io_data_ready(ready[1]),
        .io_clear_overrun(clr[1]), .io_data_valid(valid[1]), .io_data_packet(pkt_n81),
        .io_parity_error(pe[1]), .io_framing_error(fe[1]), .io_overrun(ovr[1]));

    uart_rx_fifo #(.CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .PARITY(PAR_EVEN)) u_even (
        .clk(clk), .reset(reset), .io_rx(rx[2]), .io_data_ready(ready[2]),
        .io_clear_overrun(clr[2]), .io_data_valid(valid[2]), .io_data_packet(pkt_even),
        .io_parity_error(pe[2]), .io_framing_error(fe[2]), .io_overrun(ovr[2]));

    uart_rx_fifo #(.CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7),
                   .STOP_BITS(2), .PARITY(PAR_ODD)) u_odd7 (
        .clk(clk), .reset(reset), .io_rx(rx[3]), .io_data_ready(ready[3]),
        .io_clear_overrun(clr[3]), .io_data_valid(valid[3]), .io_data_packet(pkt_odd7),
        .io_parity_error(pe[3]), .io_framing_error(fe[3]), .io_overrun(ovr[3]));

    function automatic logic [10:0] head_of(input int idx);
        case (idx)
            0:       return {fe[0], pe[0], 1'b0, pkt_def};
            1:       return {fe[1], pe[1], 1'b0, pkt_n81};
            2:       return {fe[2], pe[2], 1'b0, pkt_even};
            3:       return {fe[3], pe[3], 2'b00, pkt_odd7};
            default: return '0;
        endcase
    endfunction

    // Watches the default-rate instance for its single output pulse.
    always @(negedge clk) begin
        if (valid[0] && !v0_prev) begin
            rise_cyc  = cyc;
            mon_entry = head_of(0);
        end
        if (valid[0]) v0_high++;
        v0_prev = valid[0];
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int idx, input int bitc, input int nbits,
                              input logic [8:0] data, input int pmode, input logic bad_par,
                              input int nstop, input logic [1:0] stops, input bit keep);
        logic xr;
        logic fe_e;
        xr   = 1'b0;
        fe_e = 1'b0;
        @(negedge clk);
        start_cyc = cyc;
        rx[idx] = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx[idx] = data[i];
            xr      = xr ^ data[i];
            repeat (bitc) @(negedge clk);
        end
        if (pmode != 0) begin
            rx[idx] = ((pmode == 2) ? xr : ~xr) ^ bad_par;
            repeat (bitc) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rx[idx] = stops[i];
            if (!stops[i]) fe_e = 1'b1;
            repeat (bitc) @(negedge clk);
        end
        rx[idx] = 1'b1;
        if (keep) sb.push_back({fe_e, bad_par && (pmode != 0), data});
    endtask

    task automatic pop_check(input int idx, input string tag);
        for (int i = 0; i < 4 * FAST && !valid[idx]; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(valid[idx]), 32'd1);
        exp_e = sb.pop_front();
        check({tag, "_entry"}, 32'(head_of(idx)), 32'(exp_e));
        ready[idx] = 1'b1;
        @(negedge clk);
        ready[idx] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rx[i] = 1'b1; ready[i] = 1'b0; clr[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_valid", 32'(valid[i]), 32'd0);
            check("rst_head", 32'(head_of(i)), 32'd0);
            check("rst_ovr", 32'(ovr[i]), 32'd0);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0xA5 8N1 at 868 cycles/bit, consumer always ready
        ready[0] = 1'b1;
        send_frame(0, SLOW, 8, 9'h0A5, 0, 1'b0, 1, 2'b11, 1'b1);
        repeat (20) @(negedge clk);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'((19 * SLOW) / 2 + 3));
        check("a5_pulse_len", 32'(v0_high), 32'd1);
        exp_e = sb.pop_front();
        check("a5_entry", 32'(mon_entry), 32'(exp_e));
        check("a5_empty", 32'(valid[0]), 32'd0);
        ready[0] = 1'b0;

        // Even parity: wrong then right parity bit
        send_frame(2, FAST, 8, 9'h007, 2, 1'b1, 1, 2'b11, 1'b1);
        pop_check(2, "even_bad");
        send_frame(2, FAST, 8, 9'h007, 2, 1'b0, 1, 2'b11, 1'b1);
        pop_check(2, "even_good");

        // Short low glitch on idle line is rejected
        @(negedge clk);
        rx[1] = 1'b0;
        repeat (4) @(negedge clk);
        rx[1] = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", 32'(valid[1]), 32'd0);
        check("glitch_state", 32'(u_n81.state), 32'(IDLE));

        // Framing error on a forced-low stop bit
        send_frame(1, FAST, 8, 9'h03C, 0, 1'b0, 1, 2'b00, 1'b1);
        repeat (2 * FAST) @(negedge clk);
        pop_check(1, "framing");
        check("framing_no_extra", 32'(valid[1]), 32'd0);

        // Five frames into a 4-deep FIFO with no consumer
        for (int k = 1; k <= 5; k++)
            send_frame(1, FAST, 8, 9'(k), 0, 1'b0, 1, 2'b11, k <= 4);
        repeat (20) @(negedge clk);
        check("ovr_set", 32'(ovr[1]), 32'd1);
        ready[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(valid[1]), 32'd1);
            exp_e = sb.pop_front();
            check("drain_entry", 32'(head_of(1)), 32'(exp_e));
            @(negedge clk);
        end
        ready[1] = 1'b0;
        check("drain_empty", 32'(valid[1]), 32'd0);
        check("ovr_sticky", 32'(ovr[1]), 32'd1);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        check("ovr_cleared", 32'(ovr[1]), 32'd0);

        // 7 data bits, odd parity, two stop bits
        send_frame(3, FAST, 7, 9'h055, 1, 1'b0, 2, 2'b11, 1'b1);
        pop_check(3, "odd7_ok");
        send_frame(3, FAST, 7, 9'h055, 1, 1'b0, 2, 2'b01, 1'b1);
        repeat (2 * FAST) @(negedge clk);
        pop_check(3, "odd7_stop2");

        // Reset in the middle of a 0xFF frame with an unread entry pending
        send_frame(1, FAST, 8, 9'h099, 0, 1'b0, 1, 2'b11, 1'b1);
        repeat (4) @(negedge clk);
        check("pre_rst_valid", 32'(valid[1]), 32'd1);
        @(negedge clk);
        rx[1] = 1'b0;
        repeat (FAST) @(negedge clk);
        rx[1] = 1'b1;
        repeat (3 * FAST) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(valid[1]), 32'd0);
        check("midrst_head", 32'(head_of(1)), 32'd0);
        check("midrst_state", 32'(u_n81.state), 32'(IDLE));
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8 * FAST) @(negedge clk);
        check("post_rst_quiet", 32'(valid[1]), 32'd0);
        send_frame(1, FAST, 8, 9'h012, 0, 1'b0, 1, 2'b11, 1'b1);
        pop_check(1, "post_rst_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CLK_FREQ_HZ, 100_000_000, clock frequency.
- BAUD, 115200, line rate.
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY, PAR_NONE, parity mode (PAR_NONE, PAR_ODD, PAR_EVEN).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, at least 2).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- io_rx, in, 1, asynchronous serial line; idles high.
- io_data_ready, in, 1, consumer accepts the head entry.
- io_clear_overrun, in, 1, clears sticky overrun.
- io_data_valid, out, 1, FIFO non-empty.
- io_data_packet, out, DATA_BITS, head-entry data.
- io_parity_error, out, 1, head-entry parity error.
- io_framing_error, out, 1, head-entry stop-bit error.
- io_overrun, out, 1, sticky: a frame was dropped on a full FIFO.
REQ-003 Only clock, reset and ports: one clock domain, asynchronous active-high reset; io_rx is the only asynchronous input.

Function
REQ-004 io_rx passes through a 2-flop synchronizer (rx_s); the FSM uses rx_s only.
REQ-005 Constants: BIT_CYCLES = CLK_FREQ_HZ/BAUD; HALF_CYCLES = BIT_CYCLES/2. Bit counter is $clog2(BIT_CYCLES) bits wide.
REQ-006 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-007 IDLE: rx_s==0 -> START, counter cleared.
REQ-008 START: at counter==HALF_CYCLES-1, sample rx_s:
- 0 -> DATA, counter cleared.
- 1 (glitch) -> IDLE, nothing pushed.
REQ-009 DATA:
- Sample at counter==BIT_CYCLES-1, then clear counter.
- Shift LSB-first into a DATA_BITS shift register.
- After DATA_BITS samples: PARITY!=PAR_NONE -> PAR, else -> STOP.
REQ-010 PAR:
- Sample one bit.
- parity_err = (XOR of data and parity bit) != (PARITY==PAR_ODD).
- -> STOP.
REQ-011 STOP:
- Sample STOP_BITS bits.
- framing_err = any stop sample == 0.
- After the last stop sample: push {framing_err, parity_err, data} and -> IDLE in the same cycle (mid-stop-bit), so back-to-back frames are received.
REQ-012 Push/pop latency:
- A pushed entry appears on the outputs the cycle after the push when the FIFO was empty.
- Pop occurs when io_data_valid && io_data_ready.
REQ-013 io_data_packet/io_parity_error/io_framing_error hold the head entry while io_data_valid==1; they are 0 when empty.
REQ-014 Push onto a full FIFO with no pop that cycle:
- Frame is dropped, FIFO unchanged.
- io_overrun set the next cycle.
REQ-015 Push and pop in the same cycle while full: both occur, no overrun, occupancy unchanged.
REQ-016 Push and pop in the same cycle while holding 1 entry: new entry becomes head next cycle, io_data_valid stays 1.
REQ-017 io_overrun is cleared by io_clear_overrun. If set and clear coincide, set wins.
REQ-018 FIFO pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit so full and empty are unambiguous.

Reset
REQ-019 Reset assertion immediately forces, regardless of clock:
- FSM to IDLE; counters and shift register to 0.
- FIFO empty; io_overrun=0.
- Synchronizer flops to 1.
REQ-020 Consequence of REQ-019: io_data_valid, io_data_packet, io_parity_error and io_framing_error read 0 during reset.
REQ-021 Reset mid-frame discards the partial frame. After release, reception resumes on the next falling edge only.

Structure
REQ-022 Package uart_pkg holds:
- parity_t enum (PAR_NONE, PAR_ODD, PAR_EVEN).
- uart_rx_state_t enum.
- Helper function for the FIFO entry width (DATA_BITS+2).
REQ-023 The FIFO is sub-module sync_fifo, parametrised in WIDTH and DEPTH, with push/pop/full/empty. The FSM and synchronizer are in uart_rx_fifo.

Verification (CLK 100 MHz, BAUD 115200, BIT_CYCLES=868 unless stated)
REQ-024 Frame 0xA5, 8N1, io_data_ready=1:
- io_data_valid pulses 1 cycle.
- io_data_packet=0xA5, both error flags 0.
- Valid rises at 9.5 bit times + 3 cycles after the start edge.
REQ-025 PARITY=PAR_EVEN, frame 0x07 with parity bit 0 (wrong):
- Entry 0x07 with io_parity_error=1.
- Next frame 0x07 with parity 1 gives io_parity_error=0.
REQ-026 Low glitch of 200 cycles on an idle line: no push, FSM back to IDLE. Then frame 0x3C with stop bit forced 0: io_framing_error=1, data 0x3C.
REQ-027 FIFO_DEPTH=4, io_data_ready=0, five back-to-back frames 0x01..0x05:
- Entries 0x01..0x04 retained; io_overrun=1 after frame 5.
- Raising io_data_ready drains 0x01..0x04 in order, one per cycle.
- io_clear_overrun pulse clears io_overrun.
REQ-028 DATA_BITS=7, STOP_BITS=2, PARITY=PAR_ODD, frame 0x55: entry 0x55 with no errors. Second stop bit forced 0: io_framing_error=1.
REQ-029 Reset asserted mid-DATA of frame 0xFF:
- Outputs 0 immediately, no entry produced.
- Next full frame 0x12 is received correctly.
